// File: rtl/vend_txn_scheduler_if.sv
// rtl/vend_txn_scheduler_if.sv - requester/datapath bundle for the vending transaction scheduler
interface vend_txn_scheduler_if #(
    parameter int COUNT_W = 8
);
    logic               req_cust;
    logic               req_omoney;
    logic               req_osupply;
    logic [2:0]         product_in;
    logic [3:0]         money_in;
    logic [3:0]         qty_in;
    logic               redlight_in;

    logic [2:0]         grant;
    logic               costumer_mode;
    logic               owner_money_mode;
    logic               owner_supply_mode;
    logic [2:0]         product;
    logic [3:0]         costumer_money;
    logic [3:0]         quantitiy;
    logic               busy;
    logic               done;
    logic               err;
    logic [COUNT_W-1:0] txn_count;
    logic [COUNT_W-1:0] err_count;

    modport master (
        output req_cust, req_omoney, req_osupply,
        output product_in, money_in, qty_in, redlight_in,
        input  grant, costumer_mode, owner_money_mode, owner_supply_mode,
        input  product, costumer_money, quantitiy,
        input  busy, done, err, txn_count, err_count
    );

    modport slave (
        input  req_cust, req_omoney, req_osupply,
        input  product_in, money_in, qty_in, redlight_in,
        output grant, costumer_mode, owner_money_mode, owner_supply_mode,
        output product, costumer_money, quantitiy,
        output busy, done, err, txn_count, err_count
    );
endinterface

// File: rtl/vend_txn_scheduler.sv
// rtl/vend_txn_scheduler.sv - round-robin transaction sequencer for the vending datapath
module vend_txn_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    vend_txn_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_FIRE,
        S_SETTLE,
        S_REPORT
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [1:0]         ptr;
    logic [1:0]         win;
    logic [3:0]         settle_cnt;
    logic [2:0]         grant_q;
    logic               cm_q;
    logic               om_q;
    logic               os_q;
    logic [2:0]         product_q;
    logic [3:0]         money_q;
    logic [3:0]         qty_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [COUNT_W-1:0] txn_q;
    logic [COUNT_W-1:0] errc_q;

    logic [2:0]         req_vec;
    logic [1:0]         cand1;
    logic [1:0]         cand2;
    logic [1:0]         pick;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Priority starts at ptr and rotates upward; only indices 0..2 exist.
    always_comb begin
        req_vec = {bus.req_osupply, bus.req_omoney, bus.req_cust};
        cand1   = inc3(ptr);
        cand2   = inc3(cand1);
        pick    = cand2;
        if (req_vec[ptr]) begin
            pick = ptr;
        end else if (req_vec[cand1]) begin
            pick = cand1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= 2'd0;
            win        <= 2'd0;
            settle_cnt <= 4'd0;
            grant_q    <= 3'b000;
            cm_q       <= 1'b0;
            om_q       <= 1'b0;
            os_q       <= 1'b0;
            product_q  <= 3'd0;
            money_q    <= 4'd0;
            qty_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            txn_q      <= '0;
            errc_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_vec) begin
                        win       <= pick;
                        grant_q   <= 3'(3'b001 << pick);
                        product_q <= bus.product_in;
                        money_q   <= bus.money_in;
                        qty_q     <= bus.qty_in;
                        busy_q    <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    grant_q <= 3'b000;
                    cm_q    <= (win == 2'd0);
                    om_q    <= (win == 2'd1);
                    os_q    <= (win == 2'd2);
                    state   <= S_FIRE;
                end
                S_FIRE: begin
                    cm_q       <= 1'b0;
                    om_q       <= 1'b0;
                    os_q       <= 1'b0;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    // redlight_in is only meaningful once the datapath has committed.
                    if (settle_cnt == 4'd0) begin
                        err_q  <= bus.redlight_in;
                        done_q <= 1'b1;
                        state  <= S_REPORT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_REPORT: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    txn_q  <= txn_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    if (err_q && (errc_q != {COUNT_W{1'b1}})) begin
                        errc_q <= errc_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    end
                    ptr    <= inc3(win);
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0({cm_q, om_q, os_q}));
            assert ($onehot0(grant_q));
        end
    end

    assign bus.grant             = grant_q;
    assign bus.costumer_mode     = cm_q;
    assign bus.owner_money_mode  = om_q;
    assign bus.owner_supply_mode = os_q;
    assign bus.product           = product_q;
    assign bus.costumer_money    = money_q;
    assign bus.quantitiy         = qty_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.err               = err_q;
    assign bus.txn_count         = txn_q;
    assign bus.err_count         = errc_q;
endmodule

// File: doc/vend_txn_scheduler.md
Name: vend_txn_scheduler

Overview:
- Arbitrates and sequences vending-machine transactions onto the shared datapath that holds product supply/price storage and machine money.
- Requesters are the customer panel, owner money-withdraw and owner restock.
- Accepts level requests, picks one winner round-robin, latches its operands and fires exactly one mode strobe.
- Waits a fixed settle time for the datapath's negedge commit, then reports done/error and keeps transaction statistics.

Parameters:
SETTLE_CYCLES, 2, cycles after the mode strobe before datapath redlight is sampled (legal range 1..15)
COUNT_W, 8, width of transaction and error counters

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_cust  input  1  customer purchase request, level, held until grant
req_omoney  input  1  owner money-withdraw request, level, held until grant
req_osupply  input  1  owner restock request, level, held until grant
product_in  input  3  product index from the winning requester
money_in  input  4  customer money operand
qty_in  input  4  quantity operand (buy or restock)
redlight_in  input  1  datapath error flag, valid after settle
grant  output  3  one-hot grant pulse: bit0 cust, bit1 omoney, bit2 osupply
costumer_mode  output  1  one-cycle datapath strobe
owner_money_mode  output  1  one-cycle datapath strobe
owner_supply_mode  output  1  one-cycle datapath strobe
product  output  3  latched product index to datapath
costumer_money  output  4  latched money operand
quantitiy  output  4  latched quantity operand
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done: sampled redlight_in
txn_count  output  COUNT_W  completed transactions, wraps
err_count  output  COUNT_W  errored transactions, saturates at all-ones

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all outputs 0; operand registers 0; rr pointer 0 (customer highest priority); counters 0.
  - Reset mid-transaction aborts with no done pulse; a mode strobe in flight drops immediately.
- All outputs are registered.
- States: IDLE -> GRANT -> FIRE -> SETTLE -> REPORT -> IDLE.
- IDLE:
  - With any req high at a rising edge, select the winner by rotating priority starting at index ptr (0 cust, 1 omoney, 2 osupply).
  - Latch product_in, money_in and qty_in, whatever the requester type.
  - Drive grant one-hot for one cycle; go to GRANT.
- GRANT: grant deasserts. Assert exactly the winner's mode output for one cycle; go to FIRE.
- FIRE: mode output drops. Load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement each cycle. At the edge where the counter is 0:
  - sample redlight_in into err;
  - done<=1;
  - go to REPORT.
- REPORT (done/err high for this one cycle):
  - txn_count+1, wrapping.
  - If err, err_count+1, saturating.
  - ptr <= winner+1 mod 3.
  - Go to IDLE.
- Latency: request sampled at edge E0 gives:
  - grant for the cycle E0..E1;
  - mode strobe for E1..E2;
  - done for the cycle starting at E(2+SETTLE_CYCLES);
  - next grant possible one cycle after done ends.
  - Throughput is one transaction per 4+SETTLE_CYCLES cycles.
- At most one mode output is high in any cycle; no mode output is high outside its single-cycle strobe.
- Operands stay stable from the grant cycle until the next grant; the datapath may read them at any point in the transaction.
- Requests arriving while busy are ignored until IDLE; held levels are served later.
- A requester that keeps req high after its grant is treated as a new request and re-arbitrated with rotated priority.
- Simultaneous requests: strict rotation, so no requester waits more than two other transactions.
- redlight_in is ignored outside the SETTLE sampling edge.
- Operand widths are passed through unmodified; no arithmetic on operands.

Test Plan:
- Reset then single req_cust, product_in=3, money_in=9, qty_in=2, SETTLE_CYCLES=2, redlight_in=0:
  - grant=001 at E0+1 cycle;
  - costumer_mode high exactly one cycle at E1;
  - product=3, costumer_money=9, quantitiy=2 held;
  - done=1, err=0 at E4;
  - txn_count=1.
- All three reqs held high continuously: grants in order 001, 010, 100, 001, each 6 cycles apart, never two mode strobes in one cycle.
- req_osupply with redlight_in=1 during SETTLE:
  - done=1, err=1;
  - err_count=1;
  - owner_supply_mode was the only strobe.
- rst_n pulled low in the SETTLE cycle following a cust grant:
  - all outputs 0 immediately, no done pulse;
  - after release an idle req_omoney gets grant=010 (ptr back to 0, cust absent).
- Run 256 transactions with COUNT_W=8, all erroring:
  - txn_count wraps to 0;
  - err_count holds 255.
- req_omoney asserted while busy, mid-transaction: no grant until REPORT completes, then grant=010 on the first IDLE cycle.
